load_store_unit: RTL

//  Memory-side responder for the multicycle core's data-memory strobes. It accepts one load or store

---
 rtl/load_store_unit.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - size-aware load/store responder for a doubleword-wide data memory
// Loads are extracted and extended from the addressed lanes; sub-doubleword stores go through read-modify-write.
module load_store_unit #(
  parameter int ADDR_W  = 64,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        tam,
  input  logic              load_unsigned,
  input  logic [ADDR_W-1:0] addr,
  input  logic [63:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              misaligned,
  output logic [63:0]       load_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [63:0]       mem_wdata,
  input  logic [63:0]       mem_rdata
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RD_WAIT   = 3'd1;
  localparam logic [2:0] S_RD_DONE   = 3'd2;
  localparam logic [2:0] S_MERGE     = 3'd3;
  localparam logic [2:0] S_WR_COMMIT = 3'd4;
  localparam logic [2:0] S_ERR       = 3'd5;

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             r_we;
  logic [1:0]       r_tam;
  logic             r_us;
  logic [2:0]       r_off;
  logic [63:0]      r_wdata;
  logic [63:0]      rdata_q;

  logic             mis_in;
  logic [7:0]       size_be;
  logic [7:0]       lane_be;
  logic [63:0]      lane_mask;
  logic [63:0]      wdata_shift;
  logic [63:0]      merged;
  logic [63:0]      lane;
  logic [63:0]      ext;

  always_comb begin
    mis_in = 1'b0;
    case (tam)
      2'b00:   mis_in = (addr[2:0] != 3'b000);
      2'b01:   mis_in = (addr[1:0] != 2'b00);
      2'b10:   mis_in = addr[0];
      default: mis_in = 1'b0;
    endcase
  end

  // Byte enables of the access, moved to the addressed lane; alignment guarantees no wrap.
  always_comb begin
    size_be = 8'h01;
    case (r_tam)
      2'b00:   size_be = 8'hFF;
      2'b01:   size_be = 8'h0F;
      2'b10:   size_be = 8'h03;
      default: size_be = 8'h01;
    endcase
    lane_be = size_be << r_off;
    lane_mask = 64'd0;
    for (int i = 0; i < 8; i++) begin
      lane_mask[i*8 +: 8] = {8{lane_be[i]}};
    end
    wdata_shift = r_wdata << {r_off, 3'b000};
    merged      = (rdata_q & ~lane_mask) | (wdata_shift & lane_mask);
  end

  always_comb begin
    lane = rdata_q >> {r_off, 3'b000};
    ext  = lane;
    case (r_tam)
      2'b00:   ext = lane;
      2'b01:   ext = r_us ? {32'd0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
      2'b10:   ext = r_us ? {48'd0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
      default: ext = r_us ? {56'd0, lane[7:0]}  : {{56{lane[7]}},  lane[7:0]};
    endcase
  end

  // Each output is set on the edge that enters the state it belongs to, so everything stays registered.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      r_we       <= 1'b0;
      r_tam      <= 2'b00;
      r_us       <= 1'b0;
      r_off      <= 3'b000;
      r_wdata    <= 64'd0;
      rdata_q    <= 64'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      misaligned <= 1'b0;
      load_data  <= 64'd0;
      mem_addr   <= '0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      mem_wdata  <= 64'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (done) begin
            done <= 1'b0;
            busy <= 1'b0;
          end else if (req_valid) begin
            r_we     <= req_we;
            r_tam    <= tam;
            r_us     <= load_unsigned;
            r_off    <= addr[2:0];
            r_wdata  <= wdata;
            mem_addr <= {addr[ADDR_W-1:3], 3'b000};
            busy     <= 1'b1;
            if (mis_in) begin
              done       <= 1'b1;
              misaligned <= 1'b1;
              state      <= S_ERR;
            end else if (req_we && (tam == 2'b00)) begin
              mem_we    <= 1'b1;
              mem_wdata <= wdata;
              done      <= 1'b1;
              state     <= S_WR_COMMIT;
            end else begin
              mem_re <= 1'b1;
              cnt    <= CNT_W'(MEM_LAT - 1);
              state  <= S_RD_WAIT;
            end
          end
        end
        S_RD_WAIT: begin
          // The strobe cycle itself does not count toward the read latency.
          if (mem_re) begin
            mem_re <= 1'b0;
          end else if (cnt == '0) begin
            rdata_q <= mem_rdata;
            state   <= r_we ? S_MERGE : S_RD_DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_RD_DONE: begin
          load_data <= ext;
          done      <= 1'b1;
          state     <= S_IDLE;
        end
        S_MERGE: begin
          mem_wdata <= merged;
          mem_we    <= 1'b1;
          done      <= 1'b1;
          state     <= S_WR_COMMIT;
        end
        S_WR_COMMIT: begin
          mem_we <= 1'b0;
          done   <= 1'b0;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
        S_ERR: begin
          done       <= 1'b0;
          misaligned <= 1'b0;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
